// File: rtl/rr_arb4_sel.sv
// Four-requester round-robin arbiter with a registered grant index/enable,
// a one-cycle gap between owners and an optional bounded hold time.
module rr_arb4_sel #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic       timeout,
    output logic [1:0] ptr
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic        HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_any_req;
    logic             w_rel_norm;
    logic             w_hold_hit;

    // Rotating priority scan: lowest offset from r_ptr wins, so iterate downward.
    always_comb begin
        w_sel_idx = r_ptr;
        w_cand    = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = r_ptr + IDX_W'(k);
            if (req[w_cand]) begin
                w_sel_idx = w_cand;
            end
        end
    end

    assign w_any_req  = |req;
    assign w_rel_norm = done | ~req[r_gnt_idx];
    assign w_hold_hit = HOLD_EN & (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic; timeout only flags a release caused solely by the hold limit.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt   = ST_GRANT;
                    w_gnt_idx_nxt = w_sel_idx;
                    w_ptr_nxt     = w_sel_idx + IDX_W'(1);
                    w_cnt_nxt     = '0;
                end
            end
            ST_GRANT: begin
                if (w_rel_norm || w_hold_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = w_hold_hit & ~w_rel_norm;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt_idx = r_gnt_idx;
    assign gnt_en  = (r_state == ST_GRANT);
    assign timeout = r_timeout;
    assign ptr     = r_ptr;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Self-checking bench: three arbiters (HOLD_MAX 15, 4, 0) share stimulus and are
// compared every cycle against a behavioural owner/rotation model.
module tb_rr_arb4_sel;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [1:0] o_idx [3];
    logic       o_en  [3];
    logic       o_to  [3];
    logic [1:0] o_ptr [3];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: owner (-1 when no grant), cycles held, last index, priority pointer.
    int          m_h    [3] = '{15, 4, 0};
    int          m_own  [3];
    int          m_held [3];
    int          m_idx  [3];
    int          m_ptr  [3];
    bit          m_to   [3];

    rr_arb4_sel #(.HOLD_MAX(15), .CNT_W(4)) u_h15 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(o_idx[0]), .gnt_en(o_en[0]), .timeout(o_to[0]), .ptr(o_ptr[0])
    );
    rr_arb4_sel #(.HOLD_MAX(4), .CNT_W(3)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(o_idx[1]), .gnt_en(o_en[1]), .timeout(o_to[1]), .ptr(o_ptr[1])
    );
    rr_arb4_sel #(.HOLD_MAX(0), .CNT_W(4)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(o_idx[2]), .gnt_en(o_en[2]), .timeout(o_to[2]), .ptr(o_ptr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_own[k]  = -1;
            m_held[k] = 0;
            m_idx[k]  = 0;
            m_ptr[k]  = 0;
            m_to[k]   = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic d);
        bit found;
        bit ra, rb, rc;
        int c;
        for (int k = 0; k < 3; k++) begin
            if (m_own[k] < 0) begin
                m_to[k] = 1'b0;
                found   = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    c = (m_ptr[k] + j) % 4;
                    if (!found && r[c]) begin
                        found     = 1'b1;
                        m_own[k]  = c;
                        m_idx[k]  = c;
                        m_ptr[k]  = (c + 1) % 4;
                        m_held[k] = 1;
                    end
                end
            end else begin
                ra = d;
                rb = !r[m_own[k]];
                rc = (m_h[k] != 0) && (m_held[k] == m_h[k]);
                if (ra || rb || rc) begin
                    m_to[k]  = rc && !ra && !rb;
                    m_own[k] = -1;
                end else begin
                    m_held[k]++;
                    m_to[k] = 1'b0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("h%0d_gnt_en", m_h[k]), 32'(o_en[k]), 32'(m_own[k] >= 0));
            check($sformatf("h%0d_gnt_idx", m_h[k]), 32'(o_idx[k]), 32'(m_idx[k]));
            check($sformatf("h%0d_ptr", m_h[k]), 32'(o_ptr[k]), 32'(m_ptr[k]));
            check($sformatf("h%0d_timeout", m_h[k]), 32'(o_to[k]), 32'(m_to[k]));
        end
    endtask

    // One clock: inputs are stable across the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        logic [3:0] r_s;
        logic       d_s;
        r_s = req;
        d_s = done;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(r_s, d_s);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle();
        rst_n = 1'b1;
    endtask

    int q_idx[$];
    int q_ptr[$];
    int n_en, n_to;
    logic [3:0] en_seq;
    logic [3:0] to_seq;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        #2;
        compare_all();
        cycle();
        rst_n = 1'b1;

        // Reset asserted in the middle of a grant clears everything immediately.
        req = 4'b1111;
        repeat (3) cycle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt_en",  32'(o_en[0]),  32'd0);
        check("rst_gnt_idx", 32'(o_idx[0]), 32'd0);
        check("rst_ptr",     32'(o_ptr[0]), 32'd0);
        check("rst_timeout", 32'(o_to[0]),  32'd0);
        compare_all();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_first_grant_en",  32'(o_en[0]),  32'd1);
        check("rst_first_grant_idx", 32'(o_idx[0]), 32'd0);

        // Rotation with done pulsed in every grant cycle.
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_en[0]) begin
                q_idx.push_back(int'(o_idx[0]));
                q_ptr.push_back(int'(o_ptr[0]));
            end
        end
        check("rot_count", 32'(q_idx.size()), 32'd5);
        for (int i = 0; i < q_idx.size() && i < 5; i++) begin
            check($sformatf("rot_idx%0d", i), 32'(q_idx[i]), 32'(i % 4));
            check($sformatf("rot_ptr%0d", i), 32'(q_ptr[i]), 32'((i + 1) % 4));
        end
        done = 1'b0;

        // Skip and wrap: ptr=3 with req 0110 picks 1, then 0001 picks 0.
        do_reset();
        req = 4'b0100;
        cycle();
        check("skip_ptr3", 32'(o_ptr[0]), 32'd3);
        req = 4'b0000;
        cycle();
        req = 4'b0110;
        cycle();
        check("skip_idx1", 32'(o_idx[0]), 32'd1);
        check("skip_ptr2", 32'(o_ptr[0]), 32'd2);
        req = 4'b0001;
        cycle();
        cycle();
        check("wrap_idx0", 32'(o_idx[0]), 32'd0);
        check("wrap_ptr1", 32'(o_ptr[0]), 32'd1);

        // Forced release after HOLD_MAX=4, then re-grant; then release by done on cycle 4.
        do_reset();
        req  = 4'b0100;
        done = 1'b0;
        n_en = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            en_seq[i] = o_en[1];
            to_seq[i] = o_to[1];
        end
        check("to_en_4cycles", 32'(en_seq), 32'hF);
        check("to_no_early",   32'(to_seq), 32'h0);
        cycle();
        check("to_gap_en",    32'(o_en[1]), 32'd0);
        check("to_gap_pulse", 32'(o_to[1]), 32'd1);
        cycle();
        check("to_regrant_en",  32'(o_en[1]),  32'd1);
        check("to_regrant_idx", 32'(o_idx[1]), 32'd2);
        check("to_pulse_clear", 32'(o_to[1]),  32'd0);
        repeat (3) cycle();
        done = 1'b1;
        cycle();
        done = 1'b0;
        check("done_coincide_en", 32'(o_en[1]), 32'd0);
        check("done_coincide_to", 32'(o_to[1]), 32'd0);

        // Request drop of the owner releases after the sampling edge.
        do_reset();
        req = 4'b1010;
        cycle();
        check("drop_idx1", 32'(o_idx[0]), 32'd1);
        cycle();
        req = 4'b1000;
        cycle();
        check("drop_release", 32'(o_en[0]), 32'd0);
        cycle();
        check("drop_next_idx3", 32'(o_idx[0]), 32'd3);

        // No hold limit: a single requester keeps the grant indefinitely.
        do_reset();
        req  = 4'b1000;
        n_en = 0;
        n_to = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_en += int'(o_en[2]);
            n_to += int'(o_to[2]);
        end
        check("nolimit_en_cycles", 32'(n_en), 32'd40);
        check("nolimit_timeouts",  32'(n_to), 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            if ($urandom_range(0, 2) == 0) req = req | 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
